// File: rtl/cache_nway_wb.sv
// N-way set-associative write-back, write-allocate cache with tree pseudo-LRU,
// invalid-way-first replacement and saturating hit/miss counters.
module cache_nway_wb #(
   parameter int WAYS            = 4,
   parameter int SETS_LOG2       = 3,
   parameter int LINE_BYTES_LOG2 = 4,
   parameter int ADDR_WIDTH      = 16,
   parameter int CNT_WIDTH       = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [ADDR_WIDTH-1:0]         mem_address,
   input  logic                          mem_read,
   input  logic                          mem_write,
   input  logic [1:0]                    mem_byte_enable,
   input  logic [15:0]                   mem_wdata,
   output logic [15:0]                   mem_rdata,
   output logic                          mem_resp,
   output logic [ADDR_WIDTH-1:0]         pmem_address,
   output logic                          pmem_read,
   output logic                          pmem_write,
   output logic [(8<<LINE_BYTES_LOG2)-1:0] pmem_wdata,
   input  logic [(8<<LINE_BYTES_LOG2)-1:0] pmem_rdata,
   input  logic                          pmem_resp,
   output logic [CNT_WIDTH-1:0]          hit_count,
   output logic [CNT_WIDTH-1:0]          miss_count
);

   localparam int SETS   = 1 << SETS_LOG2;
   localparam int LINE_W = 8 << LINE_BYTES_LOG2;
   localparam int TAG_W  = ADDR_WIDTH - SETS_LOG2 - LINE_BYTES_LOG2;
   localparam int WAY_W  = $clog2(WAYS);
   localparam int OFF_W  = LINE_BYTES_LOG2 + 3;
   localparam logic [WAYS-2:0] NODE1 = 1;

   typedef enum logic [1:0] {CHECK, WB, FILL} state_t;

   state_t                    state_q;
   logic [SETS-1:0][WAYS-1:0] valid_q, dirty_q;
   logic [SETS-1:0][WAYS-2:0] plru_q;
   logic [TAG_W-1:0]          tag_q  [SETS][WAYS];
   logic [LINE_W-1:0]         data_q [SETS][WAYS];
   logic [WAY_W-1:0]          vic_q;
   logic                      replay_q;
   logic [CNT_WIDTH-1:0]      hit_q, miss_q;

   logic [SETS_LOG2-1:0] set;
   logic [TAG_W-1:0]     tag;
   logic [OFF_W-1:0]     lo_bit, hi_bit;
   logic                 req, hit, inv_found, hit_go, fill_go;
   logic [WAY_W-1:0]     hit_way, inv_way, vic;
   logic [LINE_W-1:0]    line_d;
   logic                 addr_unused;

   assign set    = mem_address[LINE_BYTES_LOG2 +: SETS_LOG2];
   assign tag    = mem_address[ADDR_WIDTH-1 -: TAG_W];
   assign lo_bit = {mem_address[LINE_BYTES_LOG2-1:1], 4'b0000};
   assign hi_bit = {mem_address[LINE_BYTES_LOG2-1:1], 4'b1000};
   assign addr_unused = mem_address[0];

   // Walk the tree: a 0 bit sends the victim search to the lower half.
   function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] p);
      logic [WAY_W-1:0] v;
      logic [WAYS-2:0]  sh;
      int               n;
      v = '0;
      n = 0;
      for (int l = 0; l < WAY_W; l++) begin
         sh = p >> n;
         v  = (v << 1) | WAY_W'(sh[0]);
         n  = 2 * n + 1 + int'(sh[0]);
      end
      return v;
   endfunction

   function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] p,
                                                  input logic [WAY_W-1:0] w);
      logic [WAYS-2:0]  r;
      logic [WAY_W-1:0] ws;
      int               n;
      r = p;
      n = 0;
      for (int l = 0; l < WAY_W; l++) begin
         ws = w >> (WAY_W - 1 - l);
         if (ws[0]) r = r & ~(NODE1 << n);
         else       r = r | (NODE1 << n);
         n = 2 * n + 1 + int'(ws[0]);
      end
      return r;
   endfunction

   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[set][w] && tag_q[set][w] == tag) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[set][w]) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
      end
      vic    = inv_found ? inv_way : plru_victim(plru_q[set]);
      line_d = data_q[set][hit_way];
      if (mem_byte_enable[0]) line_d[lo_bit +: 8] = mem_wdata[7:0];
      if (mem_byte_enable[1]) line_d[hi_bit +: 8] = mem_wdata[15:8];
   end

   assign req     = mem_read | mem_write;
   assign hit_go  = (state_q == CHECK) && req && hit && !rst;
   assign fill_go = (state_q == FILL) && pmem_resp && !rst;

   assign mem_resp   = hit_go;
   assign mem_rdata  = data_q[set][hit_way][lo_bit +: 16];
   assign pmem_read  = (state_q == FILL);
   assign pmem_write = (state_q == WB);
   assign pmem_wdata = data_q[set][vic_q];
   assign hit_count  = hit_q;
   assign miss_count = miss_q;

   always_comb begin
      if (state_q == WB)
         pmem_address = {tag_q[set][vic_q], set, {LINE_BYTES_LOG2{1'b0}}};
      else
         pmem_address = {tag, set, {LINE_BYTES_LOG2{1'b0}}};
   end

   always_ff @(posedge clk) begin
      if (hit_go && mem_write) data_q[set][hit_way] <= line_d;
      if (fill_go) begin
         data_q[set][vic_q] <= pmem_rdata;
         tag_q[set][vic_q]  <= tag;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= CHECK;
         valid_q  <= '0;
         dirty_q  <= '0;
         plru_q   <= '0;
         vic_q    <= '0;
         replay_q <= 1'b0;
         hit_q    <= '0;
         miss_q   <= '0;
      end else begin
         unique case (state_q)
            CHECK: begin
               if (req && hit) begin
                  plru_q[set] <= plru_touch(plru_q[set], hit_way);
                  replay_q    <= 1'b0;
                  if (!replay_q && !(&hit_q)) hit_q <= hit_q + CNT_WIDTH'(1);
                  if (mem_write) dirty_q[set][hit_way] <= 1'b1;
               end else if (req) begin
                  vic_q <= vic;
                  if (!(&miss_q)) miss_q <= miss_q + CNT_WIDTH'(1);
                  if (valid_q[set][vic] && dirty_q[set][vic]) state_q <= WB;
                  else                                         state_q <= FILL;
               end
            end
            WB: begin
               if (pmem_resp) state_q <= FILL;
            end
            FILL: begin
               if (pmem_resp) begin
                  valid_q[set][vic_q] <= 1'b1;
                  dirty_q[set][vic_q] <= 1'b0;
                  replay_q            <= 1'b1;
                  state_q             <= CHECK;
               end
            end
            default: state_q <= CHECK;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_nway_wb.sv
// Random and directed bench for cache_nway_wb: a flat-memory reference model
// predicts CPU responses, counters and physical-memory traffic.
module tb_cache_nway_wb;

   localparam int WAYS   = 4;
   localparam int SL     = 3;
   localparam int LBL    = 4;
   localparam int CW     = 4;
   localparam int SETS   = 1 << SL;
   localparam int LB     = 1 << LBL;
   localparam int LINE_W = 8 * LB;
   localparam int LW     = $clog2(WAYS);
   localparam int CMAX   = (1 << CW) - 1;

   typedef struct {
      bit          rd;
      logic [15:0] data;
      int          hits;
      int          miss;
   } resp_t;

   typedef struct {
      bit                wr;
      logic [15:0]       addr;
      logic [LINE_W-1:0] data;
   } pm_t;

   logic              clk = 1'b0;
   logic              rst;
   logic [15:0]       mem_address;
   logic              mem_read, mem_write;
   logic [1:0]        mem_byte_enable;
   logic [15:0]       mem_wdata, mem_rdata;
   logic              mem_resp;
   logic [15:0]       pmem_address;
   logic              pmem_read, pmem_write;
   logic [LINE_W-1:0] pmem_wdata, pmem_rdata;
   logic              pmem_resp;
   logic [CW-1:0]     hit_count, miss_count;

   cache_nway_wb #(
      .WAYS(WAYS), .SETS_LOG2(SL), .LINE_BYTES_LOG2(LBL),
      .ADDR_WIDTH(16), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst(rst),
      .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
      .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .pmem_address(pmem_address), .pmem_read(pmem_read),
      .pmem_write(pmem_write), .pmem_wdata(pmem_wdata),
      .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   resp_t resp_q[$];
   pm_t   pmem_q[$];
   bit    pm_stall = 1'b0;

   logic [7:0] pm     [65536];
   logic [7:0] ref_pm [65536];

   bit         m_valid [SETS][WAYS];
   bit         m_dirty [SETS][WAYS];
   int         m_tag   [SETS][WAYS];
   logic [7:0] m_line  [SETS][WAYS][LB];
   bit         m_plru  [SETS][WAYS-1];
   int         m_hits, m_miss;

   task automatic chk(input bit ok, input string nm,
                      input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   task automatic finish_run();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   endtask

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   function automatic int tree_victim(input int s);
      int n, v;
      n = 0;
      v = 0;
      for (int l = 0; l < LW; l++) begin
         v = v * 2 + int'(m_plru[s][n]);
         n = 2 * n + 1 + int'(m_plru[s][n]);
      end
      return v;
   endfunction

   function automatic void tree_touch(input int s, input int w);
      int n, d;
      n = 0;
      for (int l = 0; l < LW; l++) begin
         d = (w >> (LW - 1 - l)) & 1;
         m_plru[s][n] = (d == 0);
         n = 2 * n + 1 + d;
      end
   endfunction

   function automatic void model_reset();
      for (int s = 0; s < SETS; s++) begin
         for (int w = 0; w < WAYS; w++) begin
            m_valid[s][w] = 1'b0;
            m_dirty[s][w] = 1'b0;
         end
         for (int n = 0; n < WAYS - 1; n++) m_plru[s][n] = 1'b0;
      end
      m_hits = 0;
      m_miss = 0;
   endfunction

   task automatic model_access(input logic [15:0] a, input bit wr,
                               input logic [1:0] be, input logic [15:0] wd,
                               output logic [15:0] rd);
      int  s, t, o, w;
      pm_t p;
      s = (int'(a) >> LBL) % SETS;
      t = int'(a) >> (LBL + SL);
      o = (int'(a) % LB) & ~1;
      w = -1;
      for (int i = 0; i < WAYS; i++)
         if (m_valid[s][i] && m_tag[s][i] == t) w = i;
      if (w < 0) begin
         m_miss++;
         for (int i = WAYS - 1; i >= 0; i--)
            if (!m_valid[s][i]) w = i;
         if (w < 0) w = tree_victim(s);
         if (m_valid[s][w] && m_dirty[s][w]) begin
            p.wr   = 1'b1;
            p.addr = 16'((m_tag[s][w] << (LBL + SL)) | (s << LBL));
            for (int b = 0; b < LB; b++) begin
               p.data[b*8 +: 8] = m_line[s][w][b];
               ref_pm[int'(p.addr) + b] = m_line[s][w][b];
            end
            pmem_q.push_back(p);
         end
         p.wr   = 1'b0;
         p.addr = 16'(int'(a) & ~(LB - 1));
         p.data = '0;
         pmem_q.push_back(p);
         for (int b = 0; b < LB; b++) m_line[s][w][b] = ref_pm[int'(p.addr) + b];
         m_valid[s][w] = 1'b1;
         m_dirty[s][w] = 1'b0;
         m_tag[s][w]   = t;
      end else begin
         m_hits++;
      end
      tree_touch(s, w);
      if (wr) begin
         if (be[0]) m_line[s][w][o]     = wd[7:0];
         if (be[1]) m_line[s][w][o + 1] = wd[15:8];
         m_dirty[s][w] = 1'b1;
      end
      rd = {m_line[s][w][o + 1], m_line[s][w][o]};
   endtask

   task automatic access(input logic [15:0] a, input bit wr, input logic [1:0] be,
                         input logic [15:0] wd, input bit both);
      resp_t       e;
      logic [15:0] er;
      int          k;
      model_access(a, wr, be, wd, er);
      e.rd   = !wr;
      e.data = er;
      e.hits = sat(m_hits);
      e.miss = sat(m_miss);
      resp_q.push_back(e);
      mem_address     = a;
      mem_read        = !wr || both;
      mem_write       = wr;
      mem_byte_enable = be;
      mem_wdata       = wd;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!mem_resp && k < 300);
      if (!mem_resp) begin
         chk(1'b0, "access_timeout", LINE_W'(a), LINE_W'(k));
         finish_run();
      end
      @(posedge clk);
      #1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
   endtask

   // CPU must hold its request until the cache answers.
   a_hold: assert property (@(posedge clk) disable iff (rst)
      ((mem_read || mem_write) && !mem_resp) |=>
      ($stable(mem_address) && $stable(mem_read) && $stable(mem_write) &&
       $stable(mem_wdata) && $stable(mem_byte_enable)));

   initial begin : monitor
      resp_t e;
      bit    cnt_pend;
      int    exp_h, exp_m;
      cnt_pend = 1'b0;
      exp_h = 0;
      exp_m = 0;
      forever begin
         @(negedge clk);
         if (cnt_pend) begin
            chk(hit_count == CW'(exp_h), "hit_count", LINE_W'(hit_count), LINE_W'(exp_h));
            chk(miss_count == CW'(exp_m), "miss_count", LINE_W'(miss_count), LINE_W'(exp_m));
            cnt_pend = 1'b0;
         end
         if (mem_resp) begin
            if (resp_q.size() == 0) begin
               chk(1'b0, "resp_unexpected", LINE_W'(mem_address), '0);
            end else begin
               e = resp_q.pop_front();
               if (e.rd)
                  chk(mem_rdata == e.data, "rdata", LINE_W'(mem_rdata), LINE_W'(e.data));
               exp_h    = e.hits;
               exp_m    = e.miss;
               cnt_pend = 1'b1;
            end
         end
      end
   end

   initial begin : responder
      pm_t e;
      int  lat, k;
      bit  ab, skip;
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      skip       = 1'b0;
      forever begin
         if (!skip) @(negedge clk);
         skip = 1'b0;
         if (!rst && (pmem_read || pmem_write)) begin
            if (pmem_q.size() == 0) begin
               chk(1'b0, "pmem_unexpected", LINE_W'(pmem_address), '0);
            end else begin
               e = pmem_q.pop_front();
               chk(pmem_write == e.wr, "pmem_kind", LINE_W'(pmem_write), LINE_W'(e.wr));
               chk(pmem_address == e.addr, "pmem_addr", LINE_W'(pmem_address), LINE_W'(e.addr));
               if (e.wr) chk(pmem_wdata == e.data, "pmem_wdata", pmem_wdata, e.data);
            end
            lat = $urandom_range(0, 3);
            k   = 0;
            ab  = 1'b0;
            while (!ab && (k < lat || pm_stall)) begin
               @(negedge clk);
               k++;
               if (!(pmem_read || pmem_write)) ab = 1'b1;
               else if (k > 1000) begin
                  chk(1'b0, "pmem_stall_timeout", LINE_W'(k), '0);
                  finish_run();
               end
            end
            if (!ab) begin
               if (pmem_write)
                  for (int b = 0; b < LB; b++) pm[int'(pmem_address) + b] = pmem_wdata[b*8 +: 8];
               for (int b = 0; b < LB; b++) pmem_rdata[b*8 +: 8] = pm[int'(pmem_address) + b];
               pmem_resp = 1'b1;
               @(negedge clk);
               pmem_resp = 1'b0;
            end
            skip = 1'b1;
         end
      end
   end

   initial begin : driver
      logic [15:0] a, er;
      int          k;
      rst = 1'b1;
      mem_address = '0;
      mem_read = 1'b0;
      mem_write = 1'b0;
      mem_byte_enable = '0;
      mem_wdata = '0;
      for (int i = 0; i < 65536; i++) begin
         pm[i]     = 8'($urandom);
         ref_pm[i] = pm[i];
      end
      pm[16'h1234] = 8'hEF; ref_pm[16'h1234] = 8'hEF;
      pm[16'h1235] = 8'hBE; ref_pm[16'h1235] = 8'hBE;
      model_reset();

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk(!mem_resp, "rst_mem_resp", LINE_W'(mem_resp), '0);
      chk(!pmem_read && !pmem_write, "rst_pmem_req", LINE_W'({pmem_read, pmem_write}), '0);
      chk(hit_count == '0, "rst_hit_count", LINE_W'(hit_count), '0);
      chk(miss_count == '0, "rst_miss_count", LINE_W'(miss_count), '0);
      @(posedge clk);
      #1 rst = 1'b0;

      access(16'h1234, 1'b0, 2'b11, 16'h0000, 1'b0);
      access(16'h1234, 1'b1, 2'b10, 16'hAB00, 1'b0);
      access(16'h1234, 1'b0, 2'b11, 16'h0000, 1'b0);

      do_reset();
      access(16'h0030, 1'b0, 2'b11, 16'h0000, 1'b0);
      access(16'h0130, 1'b0, 2'b11, 16'h0000, 1'b0);
      access(16'h0230, 1'b0, 2'b11, 16'h0000, 1'b0);
      access(16'h0330, 1'b0, 2'b11, 16'h0000, 1'b0);
      access(16'h0130, 1'b1, 2'b11, 16'h5A3C, 1'b0);
      access(16'h0430, 1'b0, 2'b11, 16'h0000, 1'b0);
      access(16'h0530, 1'b0, 2'b11, 16'h0000, 1'b0);
      access(16'h0630, 1'b0, 2'b11, 16'h0000, 1'b0);
      access(16'h0730, 1'b0, 2'b11, 16'h0000, 1'b0);
      access(16'h0130, 1'b0, 2'b11, 16'h0000, 1'b0);

      // Abort a fill with reset, then the same address must miss again.
      do_reset();
      access(16'h2468, 1'b0, 2'b11, 16'h0000, 1'b0);
      model_access(16'h3A50, 1'b0, 2'b11, 16'h0000, er);
      pm_stall    = 1'b1;
      mem_address = 16'h3A50;
      mem_read    = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!pmem_read && k < 50);
      chk(pmem_read, "fill_started", LINE_W'(pmem_read), LINE_W'(1));
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      mem_read = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      pm_stall = 1'b0;
      @(negedge clk);
      chk(!pmem_read, "abort_pmem_read", LINE_W'(pmem_read), '0);
      chk(hit_count == '0, "abort_hit_count", LINE_W'(hit_count), '0);
      chk(miss_count == '0, "abort_miss_count", LINE_W'(miss_count), '0);
      model_reset();
      @(posedge clk);
      #1;
      access(16'h3A50, 1'b0, 2'b11, 16'h0000, 1'b0);

      do_reset();
      for (int i = 0; i < 21; i++) access(16'h4C42, 1'b0, 2'b11, 16'h0000, 1'b0);

      for (int c = 0; c < 6; c++) begin
         bit wr;
         do_reset();
         for (int i = 0; i < 14; i++) begin
            a = 16'(($urandom_range(0, 7) << (LBL + SL)) |
                    (($urandom_range(0, 1) ? 5 : 0) << LBL) |
                    $urandom_range(0, LB - 1));
            wr = 1'($urandom_range(0, 1));
            access(a, wr, 2'($urandom_range(1, 3)), 16'($urandom),
                   wr && ($urandom_range(0, 3) == 0));
         end
      end

      repeat (4) @(negedge clk);
      chk(resp_q.size() == 0, "resp_q_drained", LINE_W'(resp_q.size()), '0);
      chk(pmem_q.size() == 0, "pmem_q_drained", LINE_W'(pmem_q.size()), '0);
      finish_run();
   end

endmodule
